logic_unit_seq: RTL and testbench

//   Parametrised, handshaked logic/compare/shift unit for the tinyProcessor datapath.

---
 rtl/logic_unit_seq.sv | 132 +++++++++++++
 tb/tb_logic_unit_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// Handshaked logic/compare/shift unit: single-cycle AND/XOR/CMP/OR/NOT and
// one-bit-per-cycle SHL/SHR/ROL, with registered result and cmp/eq/zero flags.
//
//   state | meaning
//   IDLE  | waiting for start; operands sampled here only
//   SHIFT | serial shift in progress, one bit per cycle
//   DONE  | result valid, done pulse; always returns to IDLE
module logic_unit_seq #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] reg_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc_out,
  output logic             cmp_flag,
  output logic             eq_flag,
  output logic             zero_flag
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {
    OP_AND = 3'b000, OP_XOR = 3'b001, OP_CMP = 3'b010, OP_OR  = 3'b011,
    OP_NOT = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_ROL = 3'b111
  } op_t;

  state_t           state;
  op_t              shift_op;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] cnt;

  logic [CNT_W-1:0] cnt_req;
  logic             is_shift;
  logic             lt_u, lt_s, lt;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] work_next;

  assign cnt_req  = reg_val[CNT_W-1:0];
  assign is_shift = op[2] & (op[1] | op[0]);
  assign lt_u     = acc_in < reg_val;
  assign lt_s     = $signed(acc_in) < $signed(reg_val);
  assign lt       = SIGNED_CMP ? lt_s : lt_u;

  // Shifts land here only with a zero count, where the result is acc_in.
  always_comb begin
    logic_res = acc_in;
    case (op)
      OP_AND:  logic_res = acc_in & reg_val;
      OP_XOR:  logic_res = acc_in ^ reg_val;
      OP_OR:   logic_res = acc_in | reg_val;
      OP_NOT:  logic_res = ~acc_in;
      default: logic_res = acc_in;
    endcase
  end

  always_comb begin
    work_next = work;
    case (shift_op)
      OP_SHL:  work_next = {work[WIDTH-2:0], 1'b0};
      OP_SHR:  work_next = {1'b0, work[WIDTH-1:1]};
      OP_ROL:  work_next = {work[WIDTH-2:0], work[WIDTH-1]};
      default: work_next = work;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_op  <= OP_AND;
      work      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc_out   <= '0;
      cmp_flag  <= 1'b0;
      eq_flag   <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (is_shift && (cnt_req != '0)) begin
              work     <= acc_in;
              cnt      <= cnt_req;
              shift_op <= op_t'(op);
              state    <= SHIFT;
            end else begin
              acc_out   <= logic_res;
              zero_flag <= (logic_res == '0);
              if (op == OP_CMP) begin
                cmp_flag <= lt;
                eq_flag  <= (acc_in == reg_val);
              end
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            acc_out   <= work_next;
            zero_flag <= (work_next == '0);
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: cycle-level schedule model for the 8-bit unsigned
// instance, plus directed literal checks on it and on signed / 16-bit instances.
module tb_logic_unit_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [2:0] op;
  logic [7:0] acc_in, reg_val, acc_out;
  logic       busy, done, cmp_flag, eq_flag, zero_flag;

  logic       s_start;
  logic [2:0] s_op;
  logic [7:0] s_acc_in, s_reg_val, s_acc_out;
  logic       s_busy, s_done, s_cmp, s_eq, s_zero;

  logic        w_start;
  logic [2:0]  w_op;
  logic [15:0] w_acc_in, w_reg_val, w_acc_out;
  logic        w_busy, w_done, w_cmp, w_eq, w_zero;

  logic_unit_seq #(.WIDTH(8), .SIGNED_CMP(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .acc_in(acc_in), .reg_val(reg_val),
    .busy(busy), .done(done), .acc_out(acc_out),
    .cmp_flag(cmp_flag), .eq_flag(eq_flag), .zero_flag(zero_flag));

  logic_unit_seq #(.WIDTH(8), .SIGNED_CMP(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .op(s_op), .acc_in(s_acc_in), .reg_val(s_reg_val),
    .busy(s_busy), .done(s_done), .acc_out(s_acc_out),
    .cmp_flag(s_cmp), .eq_flag(s_eq), .zero_flag(s_zero));

  logic_unit_seq #(.WIDTH(16), .SIGNED_CMP(1'b0)) dut_w (
    .clk(clk), .rst(rst), .start(w_start), .op(w_op), .acc_in(w_acc_in), .reg_val(w_reg_val),
    .busy(w_busy), .done(w_done), .acc_out(w_acc_out),
    .cmp_flag(w_cmp), .eq_flag(w_eq), .zero_flag(w_zero));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: m_end is the cycle index holding the done pulse of the op in flight.
  int         m_end = -1;
  logic [7:0] m_acc = '0, p_acc = '0;
  logic       m_cmp = 1'b0, m_eq = 1'b0, m_zero = 1'b0;
  logic       p_is_cmp = 1'b0, p_cmp = 1'b0, p_eq = 1'b0;

  function automatic logic [7:0] ref_result(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] dbl;
    int n;
    n = int'(b[2:0]);
    case (o)
      3'd0: return a & b;
      3'd1: return a ^ b;
      3'd2: return a;
      3'd3: return a | b;
      3'd4: return ~a;
      3'd5: return a << n;
      3'd6: return a >> n;
      default: begin
        dbl = {a, a} << n;
        return dbl[15:8];
      end
    endcase
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_end = -1; m_acc = '0; m_cmp = 1'b0; m_eq = 1'b0; m_zero = 1'b0;
    end else begin
      if (start && (cyc - 1 > m_end)) begin
        p_acc    = ref_result(op, acc_in, reg_val);
        p_is_cmp = (op == 3'd2);
        p_cmp    = acc_in < reg_val;
        p_eq     = acc_in == reg_val;
        m_end    = cyc + ((op >= 3'd5) ? int'(reg_val[2:0]) : 0);
      end
      if (cyc == m_end) begin
        m_acc  = p_acc;
        m_zero = (p_acc == 8'h00);
        if (p_is_cmp) begin
          m_cmp = p_cmp;
          m_eq  = p_eq;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic e_busy, e_done;
    if (cyc >= 1) begin
      e_busy = (cyc <= m_end);
      e_done = (cyc == m_end);
      n_cmp++;
      if ({busy, done, acc_out, cmp_flag, eq_flag, zero_flag} !==
          {e_busy, e_done, m_acc, m_cmp, m_eq, m_zero}) begin
        n_bad++;
        $display("FAIL model_cycle cyc=%0d got busy=%b done=%b acc=%h cmp=%b eq=%b zero=%b want busy=%b done=%b acc=%h cmp=%b eq=%b zero=%b",
                 cyc, busy, done, acc_out, cmp_flag, eq_flag, zero_flag,
                 e_busy, e_done, m_acc, m_cmp, m_eq, m_zero);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Called in an IDLE cycle; returns latency and results sampled in the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [7:0] r_acc,
                        output logic r_cmp, output logic r_eq, output logic r_zero);
    op = o; acc_in = a; reg_val = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout op=%0d got no done within %0d cycles", o, lat);
    end
    r_acc = acc_out; r_cmp = cmp_flag; r_eq = eq_flag; r_zero = zero_flag;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, ndone;
    logic [7:0] r_acc;
    logic r_cmp, r_eq, r_zero;

    rst = 1'b1; start = 1'b0; op = '0; acc_in = '0; reg_val = '0;
    s_start = 1'b0; s_op = '0; s_acc_in = '0; s_reg_val = '0;
    w_start = 1'b0; w_op = '0; w_acc_in = '0; w_reg_val = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_outputs", {busy, done, acc_out, cmp_flag, eq_flag, zero_flag}, 32'h0);

    run_op(3'd0, 8'hF0, 8'h3C, lat, r_acc, r_cmp, r_eq, r_zero);
    chk("and_latency", lat, 1);
    chk("and_result", r_acc, 8'h30);
    chk("and_zero", r_zero, 1'b0);

    run_op(3'd2, 8'h05, 8'h09, lat, r_acc, r_cmp, r_eq, r_zero);
    chk("cmp_lt_pass", r_acc, 8'h05);
    chk("cmp_lt_flags", {r_cmp, r_eq}, 2'b10);
    run_op(3'd2, 8'h09, 8'h09, lat, r_acc, r_cmp, r_eq, r_zero);
    chk("cmp_eq_flags", {r_cmp, r_eq}, 2'b01);
    run_op(3'd1, 8'h09, 8'h09, lat, r_acc, r_cmp, r_eq, r_zero);
    chk("xor_result", {r_acc, r_zero}, {8'h00, 1'b1});
    chk("xor_keeps_flags", {r_cmp, r_eq}, 2'b01);

    run_op(3'd5, 8'h81, 8'h03, lat, r_acc, r_cmp, r_eq, r_zero);
    chk("shl3_latency", lat, 4);
    chk("shl3_result", r_acc, 8'h08);
    run_op(3'd7, 8'h81, 8'h01, lat, r_acc, r_cmp, r_eq, r_zero);
    chk("rol1_result", r_acc, 8'h03);
    run_op(3'd6, 8'h80, 8'h07, lat, r_acc, r_cmp, r_eq, r_zero);
    chk("shr7_latency", lat, 8);
    chk("shr7_result", r_acc, 8'h01);

    run_op(3'd5, 8'hA5, 8'h00, lat, r_acc, r_cmp, r_eq, r_zero);
    chk("shl0_latency", lat, 1);
    chk("shl0_result", r_acc, 8'hA5);
    run_op(3'd4, 8'hFF, 8'h12, lat, r_acc, r_cmp, r_eq, r_zero);
    chk("not_result", {r_acc, r_zero}, {8'h00, 1'b1});

    run_op(3'd2, 8'hFF, 8'h01, lat, r_acc, r_cmp, r_eq, r_zero);
    chk("cmp_unsigned_ff_01", {r_cmp, r_eq}, 2'b00);

    // start held high across a 5-step SHR; inputs wiggle mid-shift.
    op = 3'd6; acc_in = 8'hF0; reg_val = 8'h05; start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (i == 1) begin acc_in = 8'h0F; reg_val = 8'h01; end
    end
    chk("held_start_result", acc_out, 8'h07);
    @(posedge clk); #1;
    if (done) ndone++;
    start = 1'b0;
    chk("held_start_one_done", ndone, 1);
    chk("held_start_idle_after", busy, 1'b0);
    run_op(3'd3, 8'h0C, 8'h03, lat, r_acc, r_cmp, r_eq, r_zero);
    chk("or_after_shift", {lat[7:0], r_acc}, {8'd1, 8'h0F});

    // reset in the middle of a SHIFT
    op = 3'd5; acc_in = 8'h55; reg_val = 8'h06; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midop_reset_outputs", {busy, done, acc_out, cmp_flag, eq_flag, zero_flag}, 32'h0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midop_reset_no_done", ndone, 0);

    s_op = 3'd2; s_acc_in = 8'hFF; s_reg_val = 8'h01; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    chk("signed_cmp_done", s_done, 1'b1);
    chk("signed_cmp_ff_01", {s_acc_out, s_cmp, s_eq}, {8'hFF, 1'b1, 1'b0});

    w_op = 3'd7; w_acc_in = 16'h8001; w_reg_val = 16'h000F; w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    lat = 1;
    while (!w_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16_rol15_latency", lat, 16);
    chk("w16_rol15_result", w_acc_out, 16'hC000);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
